// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types and constants
// Provides the multiplier FSM state type and its width/iteration constants.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mult_state_t;

    localparam int MULT_WIDTH = 8;
    localparam int MULT_ITERS = 8;

endpackage

// File: rtl/adder8.sv
// rtl/adder8.sv - 8-bit ripple adder with carry and signed overflow
// Ports: a, b (addends), cin (carry in), sum, cout (carry out),
//        overflow (two's-complement overflow of the sum).
module adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout,
    output logic       overflow
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    assign overflow    = (a[7] == b[7]) && (sum[7] != a[7]);

endmodule

// File: rtl/mult8_seq.sv
// rtl/mult8_seq.sv - sequential 8x8 shift-and-add multiplier
// Ports: clk, rst (async active-high); in_valid/in_ready with a, b, signed_op
//        as the operand handshake; out_valid/out_ready with the 16-bit product
//        as the result handshake; busy is high while iterating.
module mult8_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam logic [3:0] LAST_COUNT = 4'(MULT_ITERS - 1);

    mult_state_t          state_q,     state_d;
    logic [WIDTH-1:0]     mcand_q,     mcand_d;
    logic [2*WIDTH-1:0]   acc_q,       acc_d;
    logic [3:0]           count_q,     count_d;
    logic                 neg_q,       neg_d;
    logic                 out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0]   product_q,   product_d;

    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH-1:0]     add_b;
    logic [WIDTH-1:0]     add_sum;
    logic                 add_cout;
    logic                 adder_ovf_unused;
    logic [2*WIDTH-1:0]   acc_next;

    // Magnitudes in signed mode; -128 maps to 8'h80, which reads as 128 unsigned.
    assign a_mag = (signed_op && a[WIDTH-1]) ? (~a) + WIDTH'(1) : a;
    assign b_mag = (signed_op && b[WIDTH-1]) ? (~b) + WIDTH'(1) : b;

    assign add_b = acc_q[0] ? mcand_q : '0;

    adder8 u_adder8 (
        .a        (acc_q[2*WIDTH-1:WIDTH]),
        .b        (add_b),
        .cin      (1'b0),
        .sum      (add_sum),
        .cout     (add_cout),
        .overflow (adder_ovf_unused)
    );

    // Right shift that pulls the carry into the top; the multiplier bit just
    // consumed falls off the bottom.
    assign acc_next = {add_cout, add_sum, acc_q[WIDTH-1:1]};

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        count_d     = count_q;
        neg_d       = neg_q;
        out_valid_d = out_valid_q;
        product_d   = product_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d = a_mag;
                    acc_d   = {{WIDTH{1'b0}}, b_mag};
                    neg_d   = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                    count_d = 4'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = acc_next;
                count_d = count_q + 4'd1;
                if (count_q == LAST_COUNT) begin
                    product_d   = neg_q ? (~acc_next) + (2*WIDTH)'(1) : acc_next;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            acc_q       <= '0;
            count_q     <= 4'd0;
            neg_q       <= 1'b0;
            out_valid_q <= 1'b0;
            product_q   <= '0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            neg_q       <= neg_d;
            out_valid_q <= out_valid_d;
            product_q   <= product_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = out_valid_q;
    assign product   = product_q;

endmodule
